// File: rtl/audio_i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_pkg
//  Description : Shared I2S framing constants and receiver state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_i2s_pkg;

    // BCLKs per channel slot and the Philips-mode data delay in bit clocks.
    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_DATA_DELAY = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        DELAY = 3'd2,
        SHIFT = 3'd3,
        PAD   = 3'd4
    } i2s_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_rx_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_shifter
//  Description : MSB-first serial-to-parallel shift register with a 5-bit
//                bit counter; flags the last bit and pulses done one cycle
//                after the last bit has been shifted in.
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_rx_shifter #(
    parameter int WIDTH = 24
) (
    input  logic             iAUDB_CLK,
    input  logic             reset_reg_N,
    input  logic             i_clear,
    input  logic             i_shift_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_word,
    output logic             o_last,
    output logic             o_done
);

    localparam logic [4:0] c_LAST_IDX = 5'(WIDTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [4:0]       r_bit_cnt;
    logic             r_done;
    logic             w_last;

    // The bit being shifted this cycle completes the word.
    assign w_last = i_shift_en && (r_bit_cnt == c_LAST_IDX);

    // Shift data in MSB first, count bits, and register the completion pulse.
    always_ff @(posedge iAUDB_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (i_clear) begin
                r_bit_cnt <= '0;
            end else if (i_shift_en) begin
                r_shift   <= {r_shift[WIDTH-2:0], i_bit};
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    assign o_word = r_shift;
    assign o_last = w_last;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/audio_i2s_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_receiver
//  Description : Philips-mode I2S capture from the codec ADC. Deserialises
//                left/right slots and presents a signed stereo pair with a
//                valid/ready handshake and a sticky overrun flag.
//                Optional macro AUDIO_I2S_RX_SLOT_CHECK_EN builds a slot-length
//                checker driving o_frame_err; otherwise o_frame_err is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module audio_i2s_receiver
    import audio_i2s_pkg::*;
#(
    parameter int AUD_BIT_DEPTH = 24
) (
    input  logic                     iAUDB_CLK,
    input  logic                     reset_reg_N,
    input  logic                     i2s_enable,
    input  logic                     iAUD_ADCLRCK,
    input  logic                     iAUD_ADCDAT,
    output logic [AUD_BIT_DEPTH-1:0] o_lsound_in,
    output logic [AUD_BIT_DEPTH-1:0] o_rsound_in,
    output logic                     o_sample_valid,
    input  logic                     i_sample_ready,
    output logic                     o_overrun,
    input  logic                     i_clear_flags,
    output logic                     o_frame_err
);

    i2s_rx_state_t          r_state;
    i2s_rx_state_t          w_state_nxt;
    logic                   r_lrck_dly;
    logic                   w_lrck_edge;
    logic                   w_lrck_fall;
    logic [AUD_BIT_DEPTH-1:0] w_word;
    logic                   w_last;
    logic                   w_done;
    logic                   r_cap_right;
    logic [AUD_BIT_DEPTH-1:0] r_left_hold;
    logic [AUD_BIT_DEPTH-1:0] r_lsound;
    logic [AUD_BIT_DEPTH-1:0] r_rsound;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   w_load_pair;
    logic                   w_load_left;

    assign w_lrck_edge = (r_lrck_dly != iAUD_ADCLRCK);
    assign w_lrck_fall = r_lrck_dly && !iAUD_ADCLRCK;

    i2s_rx_shifter #(
        .WIDTH (AUD_BIT_DEPTH)
    ) u_shifter (
        .iAUDB_CLK   (iAUDB_CLK),
        .reset_reg_N (reset_reg_N),
        .i_clear     (r_state == DELAY),
        .i_shift_en  (r_state == SHIFT),
        .i_bit       (iAUD_ADCDAT),
        .o_word      (w_word),
        .o_last      (w_last),
        .o_done      (w_done)
    );

    // A completed word is routed by the slot it was captured in, latched at
    // the last bit so a following LRCK edge cannot misroute it.
    assign w_load_pair = w_done && r_cap_right && i2s_enable;
    assign w_load_left = w_done && !r_cap_right;

    // LRCK history, slot side of the word in flight, and FSM state.
    always_ff @(posedge iAUDB_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_lrck_dly  <= 1'b0;
            r_cap_right <= 1'b0;
            r_state     <= IDLE;
        end else begin
            r_lrck_dly <= iAUD_ADCLRCK;
            if (w_last) begin
                r_cap_right <= r_lrck_dly;
            end
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: realign on a falling LRCK edge, abort short slots.
    always_comb begin
        w_state_nxt = r_state;
        if (!i2s_enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:  w_state_nxt = SYNC;
                SYNC:  if (w_lrck_fall) w_state_nxt = DELAY;
                DELAY: w_state_nxt = w_lrck_edge ? DELAY : SHIFT;
                SHIFT: begin
                    if (w_last) begin
                        w_state_nxt = w_lrck_edge ? DELAY : PAD;
                    end else if (w_lrck_edge) begin
                        w_state_nxt = DELAY;
                    end
                end
                PAD:   if (w_lrck_edge) w_state_nxt = DELAY;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Left holding register, output pair, handshake and sticky overrun.
    always_ff @(posedge iAUDB_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_left_hold <= '0;
            r_lsound    <= '0;
            r_rsound    <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load_left) begin
                r_left_hold <= w_word;
            end
            if (!i2s_enable) begin
                r_valid <= 1'b0;
            end else if (w_load_pair) begin
                r_lsound <= r_left_hold;
                r_rsound <= w_word;
                r_valid  <= 1'b1;
            end else if (i_sample_ready) begin
                r_valid <= 1'b0;
            end
            if (w_load_pair && r_valid && !i_sample_ready) begin
                r_overrun <= 1'b1;
            end else if (i_clear_flags) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef AUDIO_I2S_RX_SLOT_CHECK_EN
    localparam int c_SLOT_CNT_W = $clog2(I2S_SLOT_BITS) + 1;

    logic [c_SLOT_CNT_W-1:0] r_slot_cnt;
    logic                    r_frame_err;
    logic                    w_synced;
    logic                    w_slot_bad;

    assign w_synced   = (r_state == DELAY) || (r_state == SHIFT) || (r_state == PAD);
    assign w_slot_bad = w_lrck_edge && w_synced &&
                        (r_slot_cnt != c_SLOT_CNT_W'(I2S_SLOT_BITS));

    // Count BCLKs per slot (the edge cycle is the first) and flag bad lengths.
    always_ff @(posedge iAUDB_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_slot_cnt  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_lrck_edge) begin
                r_slot_cnt <= c_SLOT_CNT_W'(1);
            end else if (r_slot_cnt != '1) begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
            if (w_slot_bad) begin
                r_frame_err <= 1'b1;
            end else if (i_clear_flags) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_frame_err = r_frame_err;
`else
    assign o_frame_err = 1'b0;
`endif

    assign o_lsound_in    = r_lsound;
    assign o_rsound_in    = r_rsound;
    assign o_sample_valid = r_valid;
    assign o_overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_i2s_receiver
//  Description : Self-checking bench for audio_i2s_receiver: table-driven
//                stereo frames through a scoreboard plus hand-written
//                enable, backpressure, short-slot and reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_audio_i2s_receiver;

    localparam int W = 24;

    logic         iAUDB_CLK = 1'b0;
    logic         reset_reg_N;
    logic         i2s_enable;
    logic         iAUD_ADCLRCK;
    logic         iAUD_ADCDAT;
    logic [W-1:0] o_lsound_in;
    logic [W-1:0] o_rsound_in;
    logic         o_sample_valid;
    logic         i_sample_ready;
    logic         o_overrun;
    logic         i_clear_flags;
    logic         o_frame_err;

    audio_i2s_receiver #(
        .AUD_BIT_DEPTH (W)
    ) dut (
        .iAUDB_CLK      (iAUDB_CLK),
        .reset_reg_N    (reset_reg_N),
        .i2s_enable     (i2s_enable),
        .iAUD_ADCLRCK   (iAUD_ADCLRCK),
        .iAUD_ADCDAT    (iAUD_ADCDAT),
        .o_lsound_in    (o_lsound_in),
        .o_rsound_in    (o_rsound_in),
        .o_sample_valid (o_sample_valid),
        .i_sample_ready (i_sample_ready),
        .o_overrun      (o_overrun),
        .i_clear_flags  (i_clear_flags),
        .o_frame_err    (o_frame_err)
    );

    always #5 iAUDB_CLK = ~iAUDB_CLK;

    int cyc = 0;
    always @(posedge iAUDB_CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] l_in;
        logic [W-1:0] r_in;
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[4];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one BCLK period of LRCK/data at the falling edge.
    task automatic drive_bit(input logic lr, input logic d);
        @(negedge iAUDB_CLK);
        iAUD_ADCLRCK = lr;
        iAUD_ADCDAT  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(iAUD_ADCLRCK, 1'b1);
    endtask

    // Slot position 0 is the LRCK edge, 1 the delay bit, 2..25 the word.
    function automatic logic slot_bit(input logic [W-1:0] w, input int j);
        if (j >= 2 && j < 2 + W) return w[W + 1 - j];
        return 1'b1;
    endfunction

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                              input logic [W-1:0] el, input logic [W-1:0] er,
                              input int rlen, input bit push, input int en_at);
        for (int j = 0; j < 32; j++) drive_bit(1'b0, slot_bit(l, j));
        for (int j = 0; j < rlen; j++) begin
            if (j == en_at) i2s_enable = 1'b1;
            drive_bit(1'b1, slot_bit(r, j));
            if (push && j == W + 1) sbq.push_back('{el, er, cyc + 2});
        end
    endtask

    // Scoreboard monitor: a pair is consumed on a cycle with valid && ready.
    always begin : mon
        exp_t e;
        @(negedge iAUDB_CLK);
        #1;
        if (o_sample_valid && i_sample_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", {31'd0, o_sample_valid}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("pair_left", {8'd0, o_lsound_in}, {8'd0, e.l});
                check("pair_right", {8'd0, o_rsound_in}, {8'd0, e.r});
                if (e.cyc >= 0) check("valid_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: bench did not complete, got t=%0t expected < 300000", $time);
        $fatal(1);
    end

    initial begin
        logic exp_ferr;
        reset_reg_N    = 1'b0;
        i2s_enable     = 1'b0;
        iAUD_ADCLRCK   = 1'b1;
        iAUD_ADCDAT    = 1'b0;
        i_sample_ready = 1'b1;
        i_clear_flags  = 1'b0;

        vecs[0] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF};
        vecs[1] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
        vecs[2] = '{24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h000001};
        vecs[3] = '{24'h5A5A5A, 24'hC3C3C3, 24'h5A5A5A, 24'hC3C3C3};

        // Reset state
        repeat (3) @(negedge iAUDB_CLK);
        #1;
        check("rst_lsound", {8'd0, o_lsound_in}, 32'd0);
        check("rst_rsound", {8'd0, o_rsound_in}, 32'd0);
        check("rst_valid", {31'd0, o_sample_valid}, 32'd0);
        check("rst_overrun", {31'd0, o_overrun}, 32'd0);
        check("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
        @(negedge iAUDB_CLK);
        reset_reg_N = 1'b1;
        i2s_enable  = 1'b1;
        idle(4);

        // Normal frames, ready held high
        for (int i = 0; i < 4; i++)
            send_frame(vecs[i].l_in, vecs[i].r_in, vecs[i].exp_l, vecs[i].exp_r, 32, 1'b1, -1);
        idle(4);
        #1;
        check("stream_drained", sbq.size(), 32'd0);

        // Disable: valid low, data holds
        @(negedge iAUDB_CLK);
        i2s_enable = 1'b0;
        idle(3);
        #1;
        check("dis_valid", {31'd0, o_sample_valid}, 32'd0);
        check("dis_hold_l", {8'd0, o_lsound_in}, {8'd0, vecs[3].exp_l});
        check("dis_hold_r", {8'd0, o_rsound_in}, {8'd0, vecs[3].exp_r});

        // Enable raised mid right slot: partial frame ignored
        send_frame(24'h111111, 24'h222222, 24'h0, 24'h0, 32, 1'b0, 5);
        send_frame(24'h0F0F0F, 24'hF0F0F0, 24'h0F0F0F, 24'hF0F0F0, 32, 1'b1, -1);
        idle(2);
        #1;
        check("realign_drained", sbq.size(), 32'd0);

        // Backpressure for two frames -> overrun, then clear
        i_sample_ready = 1'b0;
        send_frame(24'h010203, 24'h040506, 24'h0, 24'h0, 32, 1'b0, -1);
        send_frame(24'h0A0B0C, 24'h0D0E0F, 24'h0, 24'h0, 32, 1'b0, -1);
        #1;
        check("bp_valid", {31'd0, o_sample_valid}, 32'd1);
        check("bp_l", {8'd0, o_lsound_in}, 32'h000A0B0C);
        check("bp_r", {8'd0, o_rsound_in}, 32'h000D0E0F);
        check("bp_overrun", {31'd0, o_overrun}, 32'd1);
        @(negedge iAUDB_CLK);
        i_clear_flags = 1'b1;
        @(negedge iAUDB_CLK);
        i_clear_flags = 1'b0;
        #1;
        check("clr_overrun", {31'd0, o_overrun}, 32'd0);
        check("clr_valid_held", {31'd0, o_sample_valid}, 32'd1);
        @(negedge iAUDB_CLK);
        sbq.push_back('{24'h0A0B0C, 24'h0D0E0F, -1});
        i_sample_ready = 1'b1;
        @(negedge iAUDB_CLK);
        #1;
        check("ack_valid", {31'd0, o_sample_valid}, 32'd0);
        check("ack_drained", sbq.size(), 32'd0);

        // Short right slot: no update, then recovery on the next frame
        send_frame(24'h13579B, 24'h2468AC, 24'h13579B, 24'h2468AC, 32, 1'b1, -1);
        send_frame(24'h777777, 24'h888888, 24'h0, 24'h0, 10, 1'b0, -1);
        #1;
        check("short_valid", {31'd0, o_sample_valid}, 32'd0);
        check("short_hold_l", {8'd0, o_lsound_in}, 32'h0013579B);
        check("short_hold_r", {8'd0, o_rsound_in}, 32'h002468AC);
        send_frame(24'h654321, 24'hFEDCBA, 24'h654321, 24'hFEDCBA, 32, 1'b1, -1);
        idle(2);
`ifdef AUDIO_I2S_RX_SLOT_CHECK_EN
        exp_ferr = 1'b1;
`else
        exp_ferr = 1'b0;
`endif
        #1;
        check("short_frame_err", {31'd0, o_frame_err}, {31'd0, exp_ferr});
        check("short_drained", sbq.size(), 32'd0);

        // Reset asserted mid-SHIFT of a left slot
        for (int j = 0; j < 12; j++) drive_bit(1'b0, slot_bit(24'h5555AA, j));
        #3;
        reset_reg_N = 1'b0;
        #1;
        check("mid_rst_l", {8'd0, o_lsound_in}, 32'd0);
        check("mid_rst_r", {8'd0, o_rsound_in}, 32'd0);
        check("mid_rst_valid", {31'd0, o_sample_valid}, 32'd0);
        check("mid_rst_overrun", {31'd0, o_overrun}, 32'd0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        reset_reg_N = 1'b1;
        send_frame(24'h999999, 24'hAAAAAA, 24'h0, 24'h0, 32, 1'b0, -1);
        send_frame(24'h1A2B3C, 24'h4D5E6F, 24'h1A2B3C, 24'h4D5E6F, 32, 1'b1, -1);
        idle(4);
        #1;
        check("final_drained", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
